// File: rtl/rf_dump_pkg.sv
// rtl/rf_dump_pkg.sv - shared types and defaults for the register-file dump engine
// RF_DUMP_SUM_EN adds the trailing checksum state.
package rf_dump_pkg;

    localparam int RF_NUM_REGS = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_SEND,
`ifdef RF_DUMP_SUM_EN
        ST_SUM,
`endif
        ST_DONE
    } rf_dump_state_t;

    // Cycles spanned from the start cycle to the done_o cycle, both inclusive, with ready held high.
    function automatic int rf_dump_cycles(input int num_regs, input bit sum_en);
        return 2 * num_regs + 2 + (sum_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/rf_dump.sv
// rtl/rf_dump.sv - sweeps the register file through a spare read port and streams it out
// RF_DUMP_SUM_EN appends a modulo-2^DATA_W checksum word carrying m_last_o.
module rf_dump
    import rf_dump_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DATA_W   = RF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] rf_read_addr_o,
    input  logic [DATA_W-1:0] rf_read_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic              m_last_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    rf_dump_state_t    state_q, state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_data_q;
    logic              is_last;

    assign is_last        = (cnt_q == LAST_ADDR);
    assign rf_read_addr_o = rd_addr_q;
    assign m_addr_o       = m_addr_q;

    // The read address is loaded with the value the counter takes on entering READ,
    // so the port sees a registered, glitch-free address for the whole READ cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            m_addr_q  <= '0;
            m_data_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        cnt_q     <= '0;
                        rd_addr_q <= '0;
                    end
                end
                ST_READ: begin
                    m_data_q <= rf_read_data_i;
                    m_addr_q <= cnt_q;
                end
                ST_SEND: begin
                    if (m_ready_i && !is_last) begin
                        cnt_q     <= cnt_q + 1'b1;
                        rd_addr_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RF_DUMP_SUM_EN
    localparam rf_dump_state_t AFTER_LAST = ST_SUM;

    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || (state_q == ST_IDLE && start_i)) begin
            sum_q <= '0;
        end else if (state_q == ST_SEND && m_ready_i) begin
            sum_q <= sum_q + m_data_q;
        end
    end

    assign m_data_o = (state_q == ST_SUM) ? sum_q : m_data_q;
    assign m_last_o = (state_q == ST_SUM);
`else
    localparam rf_dump_state_t AFTER_LAST = ST_DONE;

    assign m_data_o = m_data_q;
    assign m_last_o = (state_q == ST_SEND) && is_last;
`endif

    always_comb begin
        state_d   = state_q;
        m_valid_o = 1'b0;
        done_o    = 1'b0;
        busy_o    = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_READ;
            end
            ST_READ: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                m_valid_o = 1'b1;
                if (m_ready_i) state_d = is_last ? AFTER_LAST : ST_READ;
            end
`ifdef RF_DUMP_SUM_EN
            ST_SUM: begin
                m_valid_o = 1'b1;
                if (m_ready_i) state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rf_dump.sv
// tb/tb_rf_dump.sv - randomized self-checking bench for rf_dump against a word-list reference
// Honours RF_DUMP_SUM_EN for the expected word count and trailing checksum.
module tb_rf_dump;

    localparam int NREG = 32;
`ifdef RF_DUMP_SUM_EN
    localparam int SUM_EN = 1;
`else
    localparam int SUM_EN = 0;
`endif
    localparam int NWORDS = NREG + SUM_EN;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic [4:0]  rf_read_addr_o;
    logic [31:0] rf_read_data_i;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [31:0] m_data_o;
    logic [4:0]  m_addr_o;
    logic        m_last_o;

    rf_dump #(.NUM_REGS(NREG), .ADDR_W(5), .DATA_W(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .rf_read_addr_o (rf_read_addr_o),
        .rf_read_data_i (rf_read_data_i),
        .m_valid_o      (m_valid_o),
        .m_ready_i      (m_ready_i),
        .m_data_o       (m_data_o),
        .m_addr_o       (m_addr_o),
        .m_last_o       (m_last_o)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] rf [NREG];
    logic [31:0] exp_w [NREG];
    assign rf_read_data_i = rf[rf_read_addr_o];

    int tests = 0;
    int fails = 0;
    logic [31:0] got_d [$];
    logic [4:0]  got_a [$];
    logic        got_l [$];
    int done_cnt;
    int done_edge;
    int first_valid_edge;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload_seq();
        for (int i = 0; i < NREG; i++) rf[i] = 32'h1000_0000 + 32'(i);
        rf[0] = 32'h0;
    endtask

    task automatic preload_rand();
        for (int i = 0; i < NREG; i++) rf[i] = $urandom;
        rf[0] = 32'h0;
    endtask

    task automatic snapshot();
        for (int i = 0; i < NREG; i++) exp_w[i] = rf[i];
    endtask

    // Reference: the dump is the snapshot list in address order, plus its sum when enabled.
    task automatic verify(input string tag);
        logic [31:0] sum;
        logic [31:0] ed;
        logic [4:0]  ea;
        sum = 32'h0;
        for (int i = 0; i < NREG; i++) sum = sum + exp_w[i];
        chk({tag, " word count"}, 64'(got_d.size()), 64'(NWORDS));
        chk({tag, " done count"}, 64'(done_cnt), 64'd1);
        for (int i = 0; i < got_d.size() && i < NWORDS; i++) begin
            ed = (i < NREG) ? exp_w[i] : sum;
            ea = (i < NREG) ? 5'(i) : 5'(NREG - 1);
            chk($sformatf("%s w%0d data", tag, i), 64'(got_d[i]), 64'(ed));
            chk($sformatf("%s w%0d addr", tag, i), 64'(got_a[i]), 64'(ea));
            chk($sformatf("%s w%0d last", tag, i), 64'(got_l[i]), 64'(i == NWORDS - 1));
        end
    endtask

    task automatic run_dump(input int ready_pct, input int stall_addr, input int stall_len,
                            input int restart_at, input int wr_trig, input int wr_addr,
                            input logic [31:0] wr_data, input int rst_trig);
        int edge_idx;
        int stalled;
        int tail;
        bit wrote;
        bit pv;
        bit pr;
        logic [31:0] pd;
        logic [4:0]  pa;
        logic        pl;
        got_d.delete();
        got_a.delete();
        got_l.delete();
        done_cnt = 0;
        done_edge = -1;
        first_valid_edge = -1;
        stalled = 0;
        tail = -1;
        wrote = 0;
        pv = 0;
        pr = 0;
        pd = '0;
        pa = '0;
        pl = 1'b0;
        @(posedge clk_i);
        #1;
        start_i = 1'b1;
        m_ready_i = 1'b1;
        @(posedge clk_i);
        edge_idx = 0;
        #1;
        start_i = 1'b0;
        for (int iter = 0; iter < 800 && tail != 0; iter++) begin
            @(negedge clk_i);
            if (pv && !pr) begin
                chk("hold valid", 64'(m_valid_o), 64'd1);
                chk("hold data", 64'(m_data_o), 64'(pd));
                chk("hold addr", 64'(m_addr_o), 64'(pa));
                chk("hold last", 64'(m_last_o), 64'(pl));
            end
            if (m_valid_o && first_valid_edge < 0) first_valid_edge = edge_idx;
            if (done_o) begin
                done_cnt++;
                done_edge = edge_idx;
                if (tail < 0) tail = 5;
            end
            if (m_valid_o && m_ready_i) begin
                got_d.push_back(m_data_o);
                got_a.push_back(m_addr_o);
                got_l.push_back(m_last_o);
            end
            if (!wrote && wr_trig >= 0 && m_valid_o && 32'(m_addr_o) == wr_trig) begin
                rf[wr_addr] = wr_data;
                wrote = 1;
            end
            if (rst_trig >= 0 && m_valid_o && 32'(m_addr_o) == rst_trig) begin
                rst_i = 1'b1;
                @(posedge clk_i);
                #1;
                rst_i = 1'b0;
                chk("rst valid", 64'(m_valid_o), 64'd0);
                chk("rst busy", 64'(busy_o), 64'd0);
                chk("rst last", 64'(m_last_o), 64'd0);
                chk("rst data", 64'(m_data_o), 64'd0);
                chk("rst addr", 64'(m_addr_o), 64'd0);
                chk("rst rdaddr", 64'(rf_read_addr_o), 64'd0);
                repeat (6) begin
                    @(negedge clk_i);
                    chk("rst no done", 64'(done_o), 64'd0);
                    chk("rst idle valid", 64'(m_valid_o), 64'd0);
                end
                return;
            end
            pv = m_valid_o;
            pr = m_ready_i;
            pd = m_data_o;
            pa = m_addr_o;
            pl = m_last_o;
            @(posedge clk_i);
            edge_idx++;
            if (tail > 0) tail--;
            #1;
            start_i = (edge_idx == restart_at);
            if (m_valid_o && 32'(m_addr_o) == stall_addr && stalled < stall_len) begin
                m_ready_i = 1'b0;
                stalled++;
            end else begin
                m_ready_i = ($urandom_range(99) < ready_pct);
            end
        end
        start_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        m_ready_i = 1'b0;
        for (int i = 0; i < NREG; i++) rf[i] = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset busy", 64'(busy_o), 64'd0);
        chk("reset done", 64'(done_o), 64'd0);
        chk("reset valid", 64'(m_valid_o), 64'd0);
        chk("reset last", 64'(m_last_o), 64'd0);
        chk("reset data", 64'(m_data_o), 64'd0);
        chk("reset addr", 64'(m_addr_o), 64'd0);
        chk("reset rdaddr", 64'(rf_read_addr_o), 64'd0);
        rst_i = 1'b0;

        preload_seq();
        snapshot();
        run_dump(100, -1, 0, -1, -1, 0, 32'h0, -1);
        verify("seq");
        chk("seq first valid edge", 64'(first_valid_edge), 64'd1);
        chk("seq span", 64'(done_edge + 2), 64'(2 * NREG + 2 + SUM_EN));

        preload_seq();
        snapshot();
        run_dump(100, 7, 5, -1, -1, 0, 32'h0, -1);
        verify("stall");

        preload_rand();
        snapshot();
        run_dump(60, -1, 0, 9, -1, 0, 32'h0, -1);
        verify("restart");

        preload_seq();
        run_dump(100, 12, 3, -1, -1, 0, 32'h0, 12);
        snapshot();
        run_dump(100, -1, 0, -1, -1, 0, 32'h0, -1);
        verify("after rst");

        preload_seq();
        snapshot();
        exp_w[20] = 32'hDEAD_BEEF;
        run_dump(70, -1, 0, -1, 5, 20, 32'hDEAD_BEEF, -1);
        verify("live write");

        for (int r = 0; r < 2; r++) begin
            preload_rand();
            snapshot();
            run_dump(int'($urandom_range(90, 30)), int'($urandom_range(31)), 3, -1, -1, 0, 32'h0, -1);
            verify($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_dump.md
# rf_dump

Debug readout engine for the RISC-V register file. On a start pulse it sweeps register addresses 0..NUM_REGS-1 through one spare register-file read port and streams each value out on a valid/ready master interface, tagged with its address. It sits beside the core's register file and feeds the debug/UART transmit path. It never writes the register file.

## Interface
Parameters:
- NUM_REGS, 32, number of registers swept; must be 2..32.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset. Reset is synchronous and active-high.
- start_i  in  1  request a dump; sampled only in IDLE.
- busy_o  out  1  high from the cycle after an accepted start until DONE is left.
- done_o  out  1  one-cycle pulse after the final word's handshake.
- rf_read_addr_o  out  ADDR_W  address driven to the register-file read port.
- rf_read_data_i  in  DATA_W  combinational read data from that port.
- m_valid_o  out  1  output word valid.
- m_ready_i  in  1  downstream accepts the word.
- m_data_o  out  DATA_W  output word.
- m_addr_o  out  ADDR_W  register address of m_data_o; with the checksum word, equals NUM_REGS-1.
- m_last_o  out  1  marks the final word of the dump.

## Operation
- States: IDLE, READ, SEND, SUM (only with the macro), DONE.
- IDLE: if start_i, the address counter is cleared to 0, the checksum is cleared to 0, and the next state is READ. Otherwise remain in IDLE.
- READ (1 cycle): rf_read_addr_o = counter. At the clock edge, rf_read_data_i is registered into m_data_o and the counter into m_addr_o, and the next state is SEND.
- SEND: m_valid_o = 1. On m_valid_o && m_ready_i:
  - if counter == NUM_REGS-1, go to SUM (macro defined) or DONE;
  - otherwise increment the counter and return to READ.
- SUM: m_data_o = checksum and m_valid_o = 1. On handshake, go to DONE.
- DONE: done_o = 1 for exactly one cycle, then return to IDLE.
- m_last_o is high in SEND for the last register without the macro, and in SUM with the macro. It is low otherwise.
- While m_valid_o is high and m_ready_i is low, m_data_o, m_addr_o and m_last_o are held stable.
- m_ready_i with m_valid_o low has no effect.
- start_i outside IDLE is ignored; no queuing.
- Register x0 is emitted as whatever the register file returns, which is 0. It is not special-cased here.
- The register file is not frozen. A write to address N landing before the READ cycle of N is visible in the dump; a later write is not.
- Checksum: 32-bit sum modulo 2^32 of every emitted register word, accumulated on each SEND handshake.

## Timing
- Reset values: state IDLE; busy_o 0; done_o 0; m_valid_o 0; m_last_o 0; m_data_o 0; m_addr_o 0; rf_read_addr_o 0; counter 0; checksum 0.
- Reset mid-dump: at the next edge the block returns to IDLE with all outputs at their reset values. The partial dump is abandoned and no done_o is produced.
- Start to first m_valid_o: 2 cycles (IDLE→READ→SEND).
- Steady state with m_ready_i held high: one word per 2 cycles.
- Full dump with ready always high, from start_i to done_o:
  - 2·NUM_REGS+2 cycles without the macro;
  - +1 cycle with the macro.
- rf_read_addr_o is registered, so it is glitch-free. It holds its last value outside READ.

## Configuration
- RF_DUMP_SUM_EN defined: the SUM state exists. One extra word (the checksum) follows the last register and carries m_last_o. The dump is NUM_REGS+1 words.
- RF_DUMP_SUM_EN undefined: there is no SUM state and no checksum register. The last register word carries m_last_o. The dump is NUM_REGS words.

## Structure
- rf_dump_pkg holds:
  - the state enum (rf_dump_state_t);
  - default constants RF_NUM_REGS = 32, RF_ADDR_W = 5, RF_DATA_W = 32;
  - a sim-only helper function giving the expected cycle count.
- No sub-module. The FSM, counter and accumulator are small enough to live in one module.

## Test plan
- Preload xN = 0x1000_0000+N; pulse start_i; hold m_ready_i=1. Expect words 0x0 (x0), 0x1000_0001..0x1000_001F with m_addr_o 0..31, m_last_o only on the final word, and done_o at cycle 66 (67 with the macro).
- Same preload with the macro defined. Expect a 33rd word 0xF000_01F0 (sum of 31·0x1000_0000 and 1..31) with m_last_o=1 and m_addr_o=31.
- Backpressure: m_ready_i low for 5 cycles on word x7. Expect m_valid_o held and m_data_o stable at 0x1000_0007, with no address advance.
- Pulse start_i again mid-dump. Expect it ignored: exactly one dump and one done_o.
- Assert rst_i while word x12 is pending. Expect m_valid_o=0 and busy_o=0 the next cycle, and no done_o. A later start_i begins again from x0.
- Write x20=0xDEAD_BEEF while the sweep is at x5. Expect the dump to show 0xDEAD_BEEF at m_addr_o=20.
